// File: rtl/down_timer_if.sv
// Signal bundle for down_timer: load handshake, run controls and timer status.
// The design takes the slave modport; a driver such as a testbench takes the master.
interface down_timer_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned UNF_BITS = 8
);
  logic                en;
  logic                load_valid;
  logic                load_ready;
  logic [WIDTH-1:0]    load_value;
  logic                load_periodic;
  logic                start;
  logic                stop;
  logic [WIDTH-1:0]    count;
  logic                busy;
  logic                unf;
  logic [UNF_BITS-1:0] unf_total;

  modport slave (
    input  en, load_valid, load_value, load_periodic, start, stop,
    output load_ready, count, busy, unf, unf_total
  );

  modport master (
    output en, load_valid, load_value, load_periodic, start, stop,
    input  load_ready, count, busy, unf, unf_total
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot or periodic reload, a one-cycle underflow
// strobe and a saturating underflow event counter.
module down_timer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEFAULT_RELOAD = 25,
  parameter int unsigned UNF_BITS       = 8
) (
  input logic           clk,
  input logic           rst,
  down_timer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  state_e              r_state;
  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    r_reload;
  logic                r_periodic;
  logic                r_unf;
  logic [UNF_BITS-1:0] r_unf_total;

  logic w_load_ready;
  logic w_load_fire;

  assign w_load_ready = (r_state != StRun);
  assign w_load_fire  = bus.load_valid & w_load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_reload    <= WIDTH'(DEFAULT_RELOAD);
      r_periodic  <= 1'b0;
      r_unf       <= 1'b0;
      r_unf_total <= '0;
    end else begin
      r_unf <= 1'b0;
      unique case (r_state)
        StIdle, StExpired: begin
          if (w_load_fire) begin
            r_reload   <= bus.load_value;
            r_periodic <= bus.load_periodic;
            r_count    <= bus.load_value;
            r_state    <= StIdle;
          end
          // A same-cycle load takes effect for this start, not the stale reload.
          if (bus.start) begin
            r_count <= w_load_fire ? bus.load_value : r_reload;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (bus.stop) begin
            r_state <= StIdle;
          end else if (bus.en) begin
            if (r_count != '0) begin
              r_count <= r_count - 1'b1;
            end else begin
              r_unf <= 1'b1;
              if (r_unf_total != '1) r_unf_total <= r_unf_total + 1'b1;
              if (r_periodic) r_count <= r_reload;
              else            r_state <= StExpired;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.busy       = (r_state == StRun);
  assign bus.count      = r_count;
  assign bus.unf        = r_unf;
  assign bus.unf_total  = r_unf_total;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: per-cycle expectations are queued as stimulus is
// applied and popped when the corresponding clock edge has been taken.
module tb_down_timer;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned UNF_BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_total = 0;

  logic [WIDTH-1:0] q_count[$];
  logic             q_unf[$];

  down_timer_if #(.WIDTH(WIDTH), .UNF_BITS(UNF_BITS)) bus ();

  down_timer #(
    .WIDTH         (WIDTH),
    .DEFAULT_RELOAD(25),
    .UNF_BITS      (UNF_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en            = 1'b0;
    bus.load_valid    = 1'b0;
    bus.load_value    = '0;
    bus.load_periodic = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks += 5;
    if (bus.count !== 16'd0) begin
      n_fail++; $display("FAIL reset count: got %0d want 0", bus.count);
    end
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy);
    end
    if (bus.load_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset load_ready: got %b want 1", bus.load_ready);
    end
    if (bus.unf !== 1'b0) begin
      n_fail++; $display("FAIL reset unf: got %b want 0", bus.unf);
    end
    if (bus.unf_total !== 8'd0) begin
      n_fail++; $display("FAIL reset unf_total: got %0d want 0", bus.unf_total);
    end
  endtask

  task automatic test_oneshot_default();
    logic [WIDTH-1:0] ec;
    logic             eu;
    bus.start = 1'b1;
    bus.en    = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks += 2;
    if (bus.count !== 16'd25) begin
      n_fail++; $display("FAIL oneshot start count: got %0d want 25", bus.count);
    end
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL oneshot start busy: got %b want 1", bus.busy);
    end
    for (int j = 1; j <= 26; j++) begin
      q_count.push_back(j <= 25 ? WIDTH'(25 - j) : '0);
      q_unf.push_back(j == 26);
    end
    exp_total = 1;
    for (int j = 1; j <= 26; j++) begin
      tick();
      ec = q_count.pop_front();
      eu = q_unf.pop_front();
      n_checks += 2;
      if (bus.count !== ec) begin
        n_fail++; $display("FAIL oneshot count cyc %0d: got %0d want %0d", j, bus.count, ec);
      end
      if (bus.unf !== eu) begin
        n_fail++; $display("FAIL oneshot unf cyc %0d: got %b want %b", j, bus.unf, eu);
      end
    end
    n_checks += 3;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL oneshot expired busy: got %b want 0", bus.busy);
    end
    if (bus.load_ready !== 1'b1) begin
      n_fail++; $display("FAIL oneshot expired load_ready: got %b want 1", bus.load_ready);
    end
    if (bus.unf_total !== UNF_BITS'(exp_total)) begin
      n_fail++; $display("FAIL oneshot unf_total: got %0d want %0d", bus.unf_total, exp_total);
    end
    tick();
    n_checks += 2;
    if (bus.unf !== 1'b0) begin
      n_fail++; $display("FAIL oneshot unf width: got %b want 0", bus.unf);
    end
    if (bus.count !== 16'd0) begin
      n_fail++; $display("FAIL oneshot hold count: got %0d want 0", bus.count);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] ec;
    logic             eu;
    bus.load_valid    = 1'b1;
    bus.load_value    = 16'd3;
    bus.load_periodic = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    n_checks += 2;
    if (bus.count !== 16'd3) begin
      n_fail++; $display("FAIL periodic load count: got %0d want 3", bus.count);
    end
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL periodic load busy: got %b want 0", bus.busy);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.en    = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      q_count.push_back(WIDTH'(3 - (j % 4)));
      q_unf.push_back((j % 4) == 0);
      if ((j % 4) == 0) exp_total++;
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      ec = q_count.pop_front();
      eu = q_unf.pop_front();
      n_checks += 2;
      if (bus.count !== ec) begin
        n_fail++; $display("FAIL periodic count cyc %0d: got %0d want %0d", j, bus.count, ec);
      end
      if (bus.unf !== eu) begin
        n_fail++; $display("FAIL periodic unf cyc %0d: got %b want %b", j, bus.unf, eu);
      end
    end
    n_checks += 2;
    if (bus.unf_total !== UNF_BITS'(exp_total)) begin
      n_fail++; $display("FAIL periodic unf_total: got %0d want %0d", bus.unf_total, exp_total);
    end
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL periodic busy: got %b want 1", bus.busy);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.en   = 1'b0;
  endtask

  task automatic test_zero_reload();
    bus.load_valid    = 1'b1;
    bus.load_value    = 16'd0;
    bus.load_periodic = 1'b1;
    bus.start         = 1'b1;
    bus.en            = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    n_checks += 2;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL zero load+start busy: got %b want 1", bus.busy);
    end
    if (bus.count !== 16'd0) begin
      n_fail++; $display("FAIL zero load+start count: got %0d want 0", bus.count);
    end
    for (int j = 1; j <= 5; j++) begin
      q_count.push_back('0);
      q_unf.push_back(1'b1);
      exp_total++;
    end
    for (int j = 1; j <= 5; j++) begin
      logic [WIDTH-1:0] ec;
      logic             eu;
      tick();
      ec = q_count.pop_front();
      eu = q_unf.pop_front();
      n_checks += 2;
      if (bus.count !== ec) begin
        n_fail++; $display("FAIL zero count cyc %0d: got %0d want %0d", j, bus.count, ec);
      end
      if (bus.unf !== eu) begin
        n_fail++; $display("FAIL zero unf cyc %0d: got %b want %b", j, bus.unf, eu);
      end
    end
    bus.en = 1'b0;
    tick();
    n_checks += 3;
    if (bus.unf !== 1'b0) begin
      n_fail++; $display("FAIL zero en-low unf: got %b want 0", bus.unf);
    end
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL zero en-low busy: got %b want 1", bus.busy);
    end
    if (bus.unf_total !== UNF_BITS'(exp_total)) begin
      n_fail++; $display("FAIL zero unf_total: got %0d want %0d", bus.unf_total, exp_total);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_en_gate_and_load_in_run();
    bus.load_valid    = 1'b1;
    bus.load_value    = 16'd15;
    bus.load_periodic = 1'b0;
    bus.start         = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    bus.en         = 1'b1;
    // 15 down to 10, hold 3 cycles with en low, then 9 and 8
    for (int j = 1; j <= 5; j++) begin q_count.push_back(WIDTH'(15 - j)); q_unf.push_back(1'b0); end
    for (int j = 1; j <= 3; j++) begin q_count.push_back(16'd10); q_unf.push_back(1'b0); end
    for (int j = 1; j <= 2; j++) begin q_count.push_back(WIDTH'(10 - j)); q_unf.push_back(1'b0); end
    for (int j = 1; j <= 10; j++) begin
      logic [WIDTH-1:0] ec;
      logic             eu;
      bus.en = !(j >= 6 && j <= 8);
      tick();
      ec = q_count.pop_front();
      eu = q_unf.pop_front();
      n_checks += 2;
      if (bus.count !== ec) begin
        n_fail++; $display("FAIL engate count cyc %0d: got %0d want %0d", j, bus.count, ec);
      end
      if (bus.unf !== eu) begin
        n_fail++; $display("FAIL engate unf cyc %0d: got %b want %b", j, bus.unf, eu);
      end
    end
    bus.en            = 1'b0;
    bus.load_valid    = 1'b1;
    bus.load_value    = 16'd7;
    bus.load_periodic = 1'b1;
    #1;
    n_checks++;
    if (bus.load_ready !== 1'b0) begin
      n_fail++; $display("FAIL run load_ready: got %b want 0", bus.load_ready);
    end
    tick();
    bus.load_valid = 1'b0;
    n_checks += 2;
    if (bus.count !== 16'd8) begin
      n_fail++; $display("FAIL run load ignored count: got %0d want 8", bus.count);
    end
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL run load ignored busy: got %b want 1", bus.busy);
    end
    bus.stop = 1'b1;
    bus.en   = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.en   = 1'b0;
    n_checks += 3;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL stop busy: got %b want 0", bus.busy);
    end
    if (bus.count !== 16'd8) begin
      n_fail++; $display("FAIL stop count held: got %0d want 8", bus.count);
    end
    if (bus.load_ready !== 1'b1) begin
      n_fail++; $display("FAIL stop load_ready: got %b want 1", bus.load_ready);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.count !== 16'd15) begin
      n_fail++; $display("FAIL reload unchanged: got %0d want 15", bus.count);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop          = 1'b0;
    bus.load_valid    = 1'b1;
    bus.load_value    = 16'd5;
    bus.load_periodic = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    n_checks += 2;
    if (bus.count !== 16'd5) begin
      n_fail++; $display("FAIL idle load count: got %0d want 5", bus.count);
    end
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle load busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_saturate_and_reset();
    bus.load_valid    = 1'b1;
    bus.load_value    = 16'd1;
    bus.load_periodic = 1'b1;
    bus.start         = 1'b1;
    bus.en            = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    for (int j = 1; j <= 600; j++) begin
      q_count.push_back((j % 2) == 0 ? 16'd1 : 16'd0);
      q_unf.push_back((j % 2) == 0);
      if ((j % 2) == 0) exp_total = (exp_total >= 255) ? 255 : exp_total + 1;
    end
    for (int j = 1; j <= 600; j++) begin
      logic [WIDTH-1:0] ec;
      logic             eu;
      tick();
      ec = q_count.pop_front();
      eu = q_unf.pop_front();
      n_checks += 2;
      if (bus.count !== ec) begin
        n_fail++; $display("FAIL sat count cyc %0d: got %0d want %0d", j, bus.count, ec);
      end
      if (bus.unf !== eu) begin
        n_fail++; $display("FAIL sat unf cyc %0d: got %b want %b", j, bus.unf, eu);
      end
    end
    n_checks++;
    if (bus.unf_total !== UNF_BITS'(exp_total)) begin
      n_fail++; $display("FAIL sat unf_total: got %0d want %0d", bus.unf_total, exp_total);
    end
    // Reset away from the clock edge, with an underflow strobe still high.
    #2 rst = 1'b1;
    #1;
    n_checks += 5;
    if (bus.count !== 16'd0) begin
      n_fail++; $display("FAIL async reset count: got %0d want 0", bus.count);
    end
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL async reset busy: got %b want 0", bus.busy);
    end
    if (bus.unf !== 1'b0) begin
      n_fail++; $display("FAIL async reset unf: got %b want 0", bus.unf);
    end
    if (bus.unf_total !== 8'd0) begin
      n_fail++; $display("FAIL async reset unf_total: got %0d want 0", bus.unf_total);
    end
    if (bus.load_ready !== 1'b1) begin
      n_fail++; $display("FAIL async reset load_ready: got %b want 1", bus.load_ready);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.count !== 16'd25) begin
      n_fail++; $display("FAIL reset reload default: got %0d want 25", bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot_default();
    test_periodic();
    test_zero_reload();
    test_en_gate_and_load_in_run();
    test_saturate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
